// File: rtl/viterbi_pkg.sv
// Shared definitions for the hard-decision Viterbi decoder.
//   M, NS     : state bits / state count for the default constraint length
//   state_t   : decoder phase (S_ACS, S_TB, S_OUT)
//   exp_sym   : expected encoder symbol {y0,y1} for predecessor p and input b
//   sat_add   : unsigned add that saturates at the all-ones value of w bits
package viterbi_pkg;

  localparam int K_DEFAULT = 3;
  localparam int M         = K_DEFAULT - 1;
  localparam int NS        = 1 << M;
  localparam int SAT_W     = 16;

  typedef enum logic [1:0] {
    S_ACS = 2'd0,
    S_TB  = 2'd1,
    S_OUT = 2'd2
  } state_t;

  // The shift register is {p,b}: b is the newest bit in the LSB. Upper bits
  // of p beyond the real state width must be zero.
  function automatic logic [1:0] exp_sym(input logic [7:0] p, input logic b,
                                         input logic [7:0] g0, input logic [7:0] g1);
    logic [8:0] sr;
    sr = {p, b};
    return {^(sr & {1'b0, g0}), ^(sr & {1'b0, g1})};
  endfunction

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// Symbol-in / bit-out handshake bundle for viterbi_decoder.
//   sym_in[1:0], sym_valid, sym_ready : received symbols {y0,y1}
//   bit_out, bit_valid, bit_ready     : decoded data bits
//   frame_done                        : pulse on the last data bit transfer
// master = upstream/downstream environment, slave = decoder.
interface viterbi_decoder_if;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       frame_done;

  modport master (
    output sym_in, sym_valid, bit_ready,
    input  sym_ready, bit_out, bit_valid, frame_done
  );

  modport slave (
    input  sym_in, sym_valid, bit_ready,
    output sym_ready, bit_out, bit_valid, frame_done
  );
endinterface

// File: rtl/viterbi_acs_unit.sv
// One add-compare-select half-butterfly for a single next state.
//   pm0/bm0 : path and branch metric via predecessor x=0
//   pm1/bm1 : path and branch metric via predecessor x=1
//   pm_new  : surviving saturated metric
//   dec     : 1 when predecessor x=1 wins (ties keep x=0)
module viterbi_acs_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [SAT_W-1:0] cand0;
  logic [SAT_W-1:0] cand1;

  assign cand0  = sat_add(SAT_W'(pm0), SAT_W'(bm0), PM_W);
  assign cand1  = sat_add(SAT_W'(pm1), SAT_W'(bm1), PM_W);
  // Strict less-than so that equal metrics resolve to x=0.
  assign dec    = (cand1 < cand0);
  assign pm_new = dec ? cand1[PM_W-1:0] : cand0[PM_W-1:0];

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for a zero-terminated rate-1/2 convolutional
// frame (FRAME_LEN data symbols + K-1 tail symbols).
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : sym_in/sym_valid/sym_ready in, bit_out/bit_valid/bit_ready
//                  out, frame_done pulse on the last bit transfer
//   pm_out       : final PM[0] of the last frame (only with VITERBI_PM_OUT_EN)
// Optional feature macro: VITERBI_PM_OUT_EN adds the pm_out port and its latch.
// Phases: S_ACS accepts one symbol per cycle and updates all path metrics,
// S_TB walks the survivor array back from state 0 one step per cycle,
// S_OUT streams the buffered bits, oldest first.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int         K         = 3,
  parameter logic [7:0] G0_OCT    = 8'o07,
  parameter logic [7:0] G1_OCT    = 8'o05,
  parameter int         FRAME_LEN = 16,
  parameter int         PM_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  viterbi_decoder_if.slave bus
`ifdef VITERBI_PM_OUT_EN
  ,
  output logic [PM_W-1:0]  pm_out
`endif
);

  localparam int ST_BITS = K - 1;
  localparam int N_ST    = 1 << ST_BITS;
  localparam int STEPS   = FRAME_LEN + ST_BITS;
  localparam int STEP_W  = $clog2(STEPS);
  localparam int IDX_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STEPS - 1);
  localparam logic [STEP_W-1:0] FRAME_STEP = STEP_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0]   PM_MAX     = '1;

  state_t               state_reg;
  logic [STEP_W-1:0]    step_reg;
  logic [PM_W-1:0]      pm_reg  [N_ST];
  logic [PM_W-1:0]      pm_next [N_ST];
  logic [N_ST-1:0]      dec_vec;
  logic [N_ST-1:0]      surv_reg [STEPS];
  logic [FRAME_LEN-1:0] out_buf_reg;
  logic [ST_BITS-1:0]   tb_state_reg;
  logic [ST_BITS-1:0]   tb_state_next;
  logic [IDX_W-1:0]     idx_reg;
  logic                 sym_ready_reg;
  logic                 bit_valid_reg;
  logic                 bit_out_reg;
  logic                 sym_fire;
  logic                 bit_fire;
  logic                 tb_dec;
`ifdef VITERBI_PM_OUT_EN
  logic [PM_W-1:0]      pm_out_reg;
`endif

  assign sym_fire = sym_ready_reg && bus.sym_valid;
  assign bit_fire = bit_valid_reg && bus.bit_ready;

  // ACS array: next state gi is reached from {x, gi[M-1:1]} with input gi[0].
  for (genvar gi = 0; gi < N_ST; gi++) begin : g_acs
    localparam int         P0     = gi >> 1;
    localparam int         P1     = (1 << (ST_BITS - 1)) | (gi >> 1);
    localparam logic       IN_BIT = ((gi % 2) == 1);
    localparam logic [1:0] EXP0   = exp_sym(8'(P0), IN_BIT, G0_OCT, G1_OCT);
    localparam logic [1:0] EXP1   = exp_sym(8'(P1), IN_BIT, G0_OCT, G1_OCT);

    logic [1:0] diff0;
    logic [1:0] diff1;
    logic [1:0] bm0;
    logic [1:0] bm1;

    assign diff0 = bus.sym_in ^ EXP0;
    assign diff1 = bus.sym_in ^ EXP1;
    assign bm0   = {1'b0, diff0[1]} + {1'b0, diff0[0]};
    assign bm1   = {1'b0, diff1[1]} + {1'b0, diff1[0]};

    viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
      .pm0    (pm_reg[P0]),
      .pm1    (pm_reg[P1]),
      .bm0    (bm0),
      .bm1    (bm1),
      .pm_new (pm_next[gi]),
      .dec    (dec_vec[gi])
    );
  end

  // Traceback: the stored decision is the oldest state bit of the predecessor.
  assign tb_dec        = surv_reg[step_reg][tb_state_reg];
  assign tb_state_next = ST_BITS'({tb_dec, tb_state_reg} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_ACS;
      step_reg      <= '0;
      tb_state_reg  <= '0;
      idx_reg       <= '0;
      sym_ready_reg <= 1'b1;
      bit_valid_reg <= 1'b0;
      bit_out_reg   <= 1'b0;
      for (int i = 0; i < N_ST; i++) begin
        pm_reg[i] <= (i == 0) ? '0 : PM_MAX;
      end
`ifdef VITERBI_PM_OUT_EN
      pm_out_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        S_ACS: begin
          if (sym_fire) begin
            surv_reg[step_reg] <= dec_vec;
            for (int i = 0; i < N_ST; i++) begin
              pm_reg[i] <= pm_next[i];
            end
            if (step_reg == LAST_STEP) begin
              // step_reg stays at STEPS-1: it is the first traceback index.
              state_reg     <= S_TB;
              sym_ready_reg <= 1'b0;
              tb_state_reg  <= '0;
`ifdef VITERBI_PM_OUT_EN
              pm_out_reg    <= pm_next[0];
`endif
            end else begin
              step_reg <= step_reg + 1'b1;
            end
          end
        end

        S_TB: begin
          // Tail steps carry no data; only steps below FRAME_LEN are stored.
          if (step_reg < FRAME_STEP) begin
            out_buf_reg[step_reg[IDX_W-1:0]] <= tb_state_reg[0];
          end
          tb_state_reg <= tb_state_next;
          if (step_reg == '0) begin
            state_reg     <= S_OUT;
            idx_reg       <= '0;
            bit_valid_reg <= 1'b1;
            // Bit 0 is being written this cycle, so present it directly.
            bit_out_reg   <= tb_state_reg[0];
          end else begin
            step_reg <= step_reg - 1'b1;
          end
        end

        S_OUT: begin
          if (bit_fire) begin
            if (idx_reg == LAST_IDX) begin
              state_reg     <= S_ACS;
              bit_valid_reg <= 1'b0;
              sym_ready_reg <= 1'b1;
              step_reg      <= '0;
              for (int i = 0; i < N_ST; i++) begin
                pm_reg[i] <= (i == 0) ? '0 : PM_MAX;
              end
            end else begin
              idx_reg     <= idx_reg + 1'b1;
              bit_out_reg <= out_buf_reg[idx_reg + 1'b1];
            end
          end
        end

        default: state_reg <= S_ACS;
      endcase
    end
  end

  assign bus.sym_ready  = sym_ready_reg;
  assign bus.bit_valid  = bit_valid_reg;
  assign bus.bit_out    = bit_out_reg;
  // Same-cycle pulse: it marks the transfer itself, not the cycle after.
  assign bus.frame_done = bit_fire && (idx_reg == LAST_IDX);

`ifdef VITERBI_PM_OUT_EN
  assign pm_out = pm_out_reg;
`endif

endmodule
